// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: job sequencer that streams signed a*b terms into a pipelined DSP48A1 wrapper
// and returns the accumulated 48-bit result plus a shifted, saturated 18-bit sample.
module dsp_mac_seq #(
    parameter int LEN_W   = 5,
    parameter int DSP_LAT = 3,
    parameter int SHIFT   = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic signed [47:0]      bias,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [17:0]      in_a,
    input  logic signed [17:0]      in_b,
    input  logic                    in_sub,
    output logic [7:0]              dsp_op,
    output logic signed [17:0]      dsp_a,
    output logic signed [17:0]      dsp_b,
    output logic signed [47:0]      dsp_c,
    input  logic signed [47:0]      dsp_p,
    output logic                    res_valid,
    output logic signed [47:0]      res_p,
    output logic signed [17:0]      res_sat
);
    typedef enum logic [2:0] {IDLE, FIRST, ACC, DRAIN, DONE} state_t;

    localparam logic [7:0] OP_FIRST = 8'h0D;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_BIAS  = 8'h0C;
    localparam logic [7:0] OP_HOLD  = 8'h08;
    localparam int CW = $clog2(DSP_LAT + 1) + 1;
    localparam logic signed [47:0] SAT_MAX = 48'sd131071;
    localparam logic signed [47:0] SAT_MIN = -48'sd131072;

    state_t                 state, state_n;
    logic [LEN_W-1:0]       rem, rem_n;
    logic signed [47:0]     bias_q, bias_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   busy_n, in_ready_n, res_valid_n, hs;
    logic [7:0]             op_n;
    logic signed [17:0]     a_n, b_n, res_sat_n, sat;
    logic signed [47:0]     c_n, res_p_n, shifted;

    assign hs      = in_valid && in_ready;
    assign shifted = dsp_p >>> SHIFT;
    assign sat     = shifted > SAT_MAX ? 18'sh1FFFF : shifted < SAT_MIN ? 18'sh20000 : shifted[17:0];

    always_comb begin
        state_n     = state;
        rem_n       = rem;
        bias_n      = bias_q;
        cnt_n       = cnt;
        busy_n      = busy;
        in_ready_n  = 1'b0;
        op_n        = OP_HOLD;
        a_n         = '0;
        b_n         = '0;
        c_n         = dsp_c;
        res_valid_n = 1'b0;
        res_p_n     = res_p;
        res_sat_n   = res_sat;
        case (state)
            IDLE: if (start) begin
                bias_n = bias;
                busy_n = 1'b1;
                cnt_n  = '0;
                rem_n  = len;
                if (len == '0) begin
                    op_n    = OP_BIAS;
                    c_n     = bias;
                    state_n = DRAIN;
                end else begin
                    in_ready_n = 1'b1;
                    state_n    = FIRST;
                end
            end
            FIRST, ACC: begin
                in_ready_n = 1'b1;
                if (hs) begin
                    // first term seeds P from C (bias); later terms accumulate onto P
                    op_n       = (state == FIRST ? OP_FIRST : OP_ACC) | {in_sub, 7'b0};
                    a_n        = in_a;
                    b_n        = in_b;
                    c_n        = state == FIRST ? bias_q : dsp_c;
                    rem_n      = rem - 1'b1;
                    in_ready_n = rem != LEN_W'(1);
                    state_n    = rem == LEN_W'(1) ? DRAIN : ACC;
                end
            end
            DRAIN: begin
                // dsp_p holds the final sum once DSP_LAT edges have passed the last issue
                if (cnt == CW'(DSP_LAT)) begin
                    state_n     = DONE;
                    res_valid_n = 1'b1;
                    busy_n      = 1'b0;
                    res_p_n     = dsp_p;
                    res_sat_n   = sat;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            bias_q    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            dsp_op    <= OP_HOLD;
            dsp_a     <= '0;
            dsp_b     <= '0;
            dsp_c     <= '0;
            res_valid <= 1'b0;
            res_p     <= '0;
            res_sat   <= '0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            bias_q    <= bias_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            in_ready  <= in_ready_n;
            dsp_op    <= op_n;
            dsp_a     <= a_n;
            dsp_b     <= b_n;
            dsp_c     <= c_n;
            res_valid <= res_valid_n;
            res_p     <= res_p_n;
            res_sat   <= res_sat_n;
        end
    end
endmodule

// File: doc/dsp_mac_seq.md
Name: dsp_mac_seq

Overview:
- Initiator for the pipelined DSP48A1 multiplier/post-adder wrapper.
- Accepts a job (term count, 48-bit bias), then streams (a, b, add/sub) term pairs over a valid/ready handshake.
- Issues the matching opmode/operand words to the DSP and tracks its fixed pipeline latency.
- Returns the accumulated 48-bit result plus a shifted, saturated 18-bit sample.
- Used by filter and oscillator blocks that share one DSP slice.

Parameters:
- LEN_W, 5: width of the term count; up to 2^LEN_W-1 terms per job.
- DSP_LAT, 3: clocks from issuing op/a/b/c to the result appearing on dsp_p.
- SHIFT, 17: arithmetic right shift applied before 18-bit saturation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  job start pulse; sampled only in IDLE
- len  in  LEN_W  number of terms in the job
- bias  in  48 signed  initial accumulator value
- busy  out  1  high from the accepted start until res_valid
- in_valid  in  1  term available
- in_ready  out  1  term accepted when in_valid && in_ready
- in_a  in  18 signed  multiplicand
- in_b  in  18 signed  multiplier
- in_sub  in  1  1: subtract product; 0: add product
- dsp_op  out  8  opmode word to DSP wrapper
- dsp_a  out  18 signed  A operand
- dsp_b  out  18 signed  B operand
- dsp_c  out  48 signed  C operand
- dsp_p  in  48 signed  DSP result
- res_valid  out  1  one-cycle result strobe
- res_p  out  48 signed  full accumulator
- res_sat  out  18 signed  saturate(res_p >>> SHIFT)

Behaviour:
- Clock and reset: all outputs registered. Reset is clk, asynchronous, active-high.
- Reset values: busy=0, in_ready=0, res_valid=0, res_p=0, res_sat=0, dsp_op=8'h08, dsp_a=0, dsp_b=0, dsp_c=0.
- Opmode encodings:
  - FIRST_ADD=8'h0D (C+M); FIRST_SUB=8'h8D (C−M)
  - ACC_ADD=8'h09 (P+M); ACC_SUB=8'h89 (P−M)
  - BIAS_ONLY=8'h0C (C+0); HOLD=8'h08 (P+0)
- States: IDLE, FIRST, ACC, DRAIN, DONE.
- IDLE:
  - in_ready=0; dsp_op=HOLD, dsp_a/dsp_b=0.
  - On start: latch len and bias, set busy=1.
  - len==0: issue BIAS_ONLY with dsp_c=bias next cycle, go to DRAIN.
  - Otherwise go to FIRST.
- FIRST:
  - in_ready=1.
  - On handshake: issue FIRST_ADD/SUB with dsp_a=in_a, dsp_b=in_b, dsp_c=bias, and remaining=len−1.
  - Then go to DRAIN if remaining==0, else ACC.
  - With no handshake: issue HOLD, a=b=0.
- ACC:
  - in_ready=1.
  - On handshake: issue ACC_ADD/SUB, decrement remaining, go to DRAIN when it reaches 0.
  - Bubble (in_valid=0): issue HOLD with a=b=0, accumulator unchanged.
- DRAIN:
  - in_ready=0; issue HOLD.
  - Count DSP_LAT cycles from the last issue, then go to DONE.
- DONE:
  - Register res_p=dsp_p and res_sat.
  - res_valid=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: res_valid is high in the cycle following edge T+DSP_LAT+1, where T is the edge that issued the last op.
- Saturation: s = res_p >>> SHIFT.
  - s > 131071 → 131071.
  - s < −131072 → −131072.
  - Otherwise s[17:0].
- Ignored inputs:
  - start outside IDLE is ignored.
  - start and res_valid in the same cycle: start is ignored, because the FSM is in DONE.
  - in_valid outside FIRST/ACC is ignored; in_ready=0 there.
- in_ready combines state and the registered count. It drops in the cycle after the final handshake, so no extra term is taken.
- Reset mid-job: all outputs return to reset values immediately and the FSM returns to IDLE. The DSP wrapper shares the reset. No partial result is ever strobed.
- Back-to-back jobs: a new start is accepted in the IDLE cycle right after DONE.

Test Plan:
1. len=3, bias=0; terms (2,3,add), (4,5,add), (−1,7,add), in_valid always high → res_p=19, res_sat=0. res_valid high in the cycle following edge T+4 (T = issue edge of the third term), one cycle wide; exactly 3 handshakes.
2. len=2, bias=100; (10,10,add), (3,4,sub) → res_p=188. dsp_op sequence 8'h0D, 8'h89, then 8'h08 during drain.
3. Scenario 1 with in_valid toggling 1,0,0,1,0,1 → res_p=19. HOLD issued on every bubble; res_valid DSP_LAT+1 edges after the last handshake.
4. len=0, bias=−5 → single 8'h0C issue, no handshakes, res_p=−5, res_sat=−1. start pulsed during busy has no effect.
5. len=16, a=b=131071, all add → res_p=274873712656, res_sat=131071. Same job with all sub → res_sat=−131072.
6. Assert reset after 2 of 4 terms → busy/in_ready/res_valid=0, dsp_op=8'h08, no strobe. Rerun scenario 1 → res_p=19.
